// File: rtl/prog_load_sequencer.sv
// Loads DEPTH {instruction, data} pairs into the 4-bit computer through its programming
// port, then lets it run for RUN_CYCLES clocks and captures its data_out as the result.
module prog_load_sequencer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int STROBE_W   = 1,
    parameter int RUN_CYCLES = 32
) (
    input  logic              osc_clock,
    input  logic              reset,
    input  logic              start,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [7:0]        word_prog,
    input  logic [3:0]        word_data,
    output logic [7:0]        prog_in,
    output logic [3:0]        data_in,
    output logic [ADDR_W-1:0] prog_add,
    output logic              prog_clk,
    output logic              cpu_reset,
    input  logic [3:0]        cpu_data_out,
    output logic [3:0]        result,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_RUN, S_DONE
    } state_t;

    localparam int RC_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam int SC_W = (STROBE_W > 1) ? $clog2(STROBE_W) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [RC_W-1:0]   RUN_LAST  = RC_W'(RUN_CYCLES - 1);
    localparam logic [SC_W-1:0]   STB_LAST  = SC_W'(STROBE_W - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RC_W-1:0]   run_cnt_q, run_cnt_d;
    logic [SC_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [7:0]        prog_in_q;
    logic [3:0]        data_in_q;
    logic [ADDR_W-1:0] prog_add_q;
    logic              prog_clk_q, cpu_reset_q, word_ready_q, busy_q, done_q;
    logic [3:0]        result_q;

    assign addr_d    = addr_q + ADDR_W'(1);
    assign run_cnt_d = run_cnt_q + RC_W'(1);
    assign stb_cnt_d = stb_cnt_q + SC_W'(1);

    always_ff @(posedge osc_clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            run_cnt_q    <= '0;
            stb_cnt_q    <= '0;
            prog_in_q    <= '0;
            data_in_q    <= '0;
            prog_add_q   <= '0;
            prog_clk_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
            word_ready_q <= 1'b0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_WAIT;
                        addr_q       <= '0;
                        done_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        word_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // prog_add only moves here, so it never changes under a live strobe
                    if (word_valid && word_ready_q) begin
                        prog_in_q    <= word_prog;
                        data_in_q    <= word_data;
                        prog_add_q   <= addr_q;
                        word_ready_q <= 1'b0;
                        state_q      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    prog_clk_q <= 1'b1;
                    stb_cnt_q  <= '0;
                    state_q    <= S_STROBE;
                end
                S_STROBE: begin
                    if (stb_cnt_q == STB_LAST) begin
                        prog_clk_q <= 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            cpu_reset_q <= 1'b0;
                            run_cnt_q   <= '0;
                            state_q     <= S_RUN;
                        end else begin
                            addr_q       <= addr_d;
                            word_ready_q <= 1'b1;
                            state_q      <= S_WAIT;
                        end
                    end else begin
                        stb_cnt_q <= stb_cnt_d;
                    end
                end
                S_RUN: begin
                    if (run_cnt_q == RUN_LAST) begin
                        result_q    <= cpu_data_out;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        run_cnt_q <= run_cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign word_ready = word_ready_q;
    assign prog_in    = prog_in_q;
    assign data_in    = data_in_q;
    assign prog_add   = prog_add_q;
    assign prog_clk   = prog_clk_q;
    assign cpu_reset  = cpu_reset_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Directed bench: full load, backpressure, run capture, mid-load reset, spurious inputs, re-run.
module tb_prog_load_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          osc_clock = 1'b0;
    logic          reset = 1'b1, start = 1'b0, word_valid = 1'b0;
    logic          word_ready;
    logic [7:0]    word_prog = '0;
    logic [3:0]    word_data = '0;
    logic [7:0]    prog_in;
    logic [3:0]    data_in;
    logic [AW-1:0] prog_add;
    logic          prog_clk, cpu_reset;
    logic [3:0]    cpu_data_out = '0;
    logic [3:0]    result;
    logic          busy, done;

    prog_load_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .STROBE_W(1), .RUN_CYCLES(32)) dut (
        .osc_clock(osc_clock), .reset(reset), .start(start), .word_valid(word_valid),
        .word_ready(word_ready), .word_prog(word_prog), .word_data(word_data),
        .prog_in(prog_in), .data_in(data_in), .prog_add(prog_add), .prog_clk(prog_clk),
        .cpu_reset(cpu_reset), .cpu_data_out(cpu_data_out), .result(result),
        .busy(busy), .done(done)
    );

    always #5 osc_clock = ~osc_clock;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: strobe edges, strobe width, word/setup integrity, cpu_reset low time
    int   cyc = 0, nr = 0, hi = 0, lowcnt = 0, low_start = 0;
    int   rise_add[128];
    int   rise_cyc[128];
    logic prev_pc = 1'b0, prev_cr = 1'b1;
    logic [7:0] prev_prog = '0;

    always @(posedge osc_clock) cyc++;

    always @(negedge osc_clock) begin
        if (prog_clk && !prev_pc) begin
            if (nr < 128) begin
                rise_add[nr] = int'(prog_add);
                rise_cyc[nr] = cyc;
            end
            nr++;
            hi = 1;
            chk("rise_prog", prog_in, 8'h60 + prog_add);
            chk("rise_data", data_in, prog_add);
            chk("setup_prog", prev_prog, 8'h60 + prog_add);
        end else if (prog_clk) begin
            hi++;
        end else if (prev_pc) begin
            chk("strobe_w", hi, 1);
        end
        if (prog_clk && !cpu_reset) chk("pclk_in_run", 1, 0);
        if (!cpu_reset) lowcnt++;
        if (!cpu_reset && prev_cr) low_start = cyc;
        prev_pc   = prog_clk;
        prev_cr   = cpu_reset;
        prev_prog = prog_in;
    end

    task automatic pulse_start();
        @(negedge osc_clock) start = 1'b1;
        @(negedge osc_clock) start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", word_ready, 1);
        chk("start_done", done, 0);
    endtask

    // Host driver; gap_at: index after which valid drops for 5 cycles,
    // spur_at: word index during which start is held, abort_at: prog_add to reset in STROBE
    task automatic host_load(input int gap_at, input int spur_at, input int abort_at);
        int i = 0, gap = 0, n = 0;
        bit acc = 0;
        while (i < DEPTH && n < 2000) begin
            if (abort_at >= 0 && prog_clk && int'(prog_add) == abort_at) begin
                reset = 1'b1;
                break;
            end
            start = (spur_at >= 0 && i == spur_at);
            if (gap > 0) begin
                word_valid = 1'b0;
                acc = 0;
                gap--;
                chk("gap_prog", prog_in, 8'(8'h60 + i - 1));
                chk("gap_data", data_in, 4'(i - 1));
            end else begin
                word_valid = 1'b1;
                word_prog  = 8'(8'h60 + i);
                word_data  = 4'(i);
                acc = word_ready;
            end
            @(negedge osc_clock);
            n++;
            if (acc) begin
                i++;
                if (i == gap_at) gap = 5;
            end
        end
        word_valid = 1'b0;
        start = 1'b0;
        if (n >= 2000) chk("load_timeout", n, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge osc_clock);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic check_load(input string tag, input int base, input int cnt);
        chk({tag, "_nrises"}, nr - base, cnt);
        for (int k = 0; k < cnt && base + k < 128; k++)
            chk({tag, "_add"}, rise_add[base + k], k);
    endtask

    task automatic check_run(input int l0, input int last_rise, input logic [3:0] exp_res);
        chk("run_low_cycles", lowcnt - l0, 32);
        chk("run_low_start", low_start, last_rise + 1);
        chk("run_result", result, exp_res);
        chk("run_busy", busy, 0);
        chk("run_cpu_reset", cpu_reset, 1);
    endtask

    initial begin
        int base, l0;
        repeat (3) @(negedge osc_clock);
        chk("rst_ready", word_ready, 0);
        chk("rst_prog_in", prog_in, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_prog_add", prog_add, 0);
        chk("rst_prog_clk", prog_clk, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        word_valid = 1'b1;
        @(negedge osc_clock);
        chk("idle_ignores_valid", word_ready, 0);
        chk("idle_busy", busy, 0);
        word_valid = 1'b0;

        // Full load, host always valid, then run with data_out = 8
        cpu_data_out = 4'd8;
        base = nr; l0 = lowcnt;
        pulse_start();
        host_load(-1, -1, -1);
        wait_done();
        check_load("full", base, 16);
        for (int k = 1; k < 16; k++)
            chk("word_period", rise_cyc[base + k] - rise_cyc[base + k - 1], 3);
        check_run(l0, rise_cyc[base + 15], 4'd8);
        @(negedge osc_clock);
        chk("done_sticky", done, 1);

        // Re-run from DONE with backpressure after word 3 and start held at word 5
        cpu_data_out = 4'd5;
        base = nr; l0 = lowcnt;
        pulse_start();
        host_load(4, 5, -1);
        wait_done();
        check_load("bp", base, 16);
        check_run(l0, rise_cyc[base + 15], 4'd5);

        // Reset while prog_add = 7 is strobing, then reload from 0
        base = nr;
        pulse_start();
        host_load(-1, -1, 7);
        @(negedge osc_clock);
        chk("abort_prog_clk", prog_clk, 0);
        chk("abort_cpu_reset", cpu_reset, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ready", word_ready, 0);
        chk("abort_prog_add", prog_add, 0);
        chk("abort_nrises", nr - base, 8);
        reset = 1'b0;
        cpu_data_out = 4'hA;
        base = nr; l0 = lowcnt;
        pulse_start();
        host_load(-1, -1, -1);
        wait_done();
        check_load("reload", base, 16);
        check_run(l0, rise_cyc[base + 15], 4'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
